// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_pkg
// Brief    : Joystick bit indices, direction and coin-FSM types for the mapper.
// Revision : 1.0  initial release
// ============================================================================
package arcade_input_pkg;

  localparam int c_JOY_RIGHT = 0;
  localparam int c_JOY_LEFT  = 1;
  localparam int c_JOY_DOWN  = 2;
  localparam int c_JOY_UP    = 3;
  localparam int c_JOY_COIN  = 4;
  localparam int c_JOY_START = 5;
  localparam int c_RAW_BITS  = 6;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_U    = 3'd1,
    DIR_D    = 3'd2,
    DIR_L    = 3'd3,
    DIR_R    = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    COIN_IDLE         = 2'd0,
    COIN_PULSE        = 2'd1,
    COIN_WAIT_RELEASE = 2'd2
  } coin_state_t;

  // Highest-priority direction in a set, U > D > L > R.
  function automatic dir_t dir_from_bits(input logic [3:0] v);
    dir_t d;
    if (v[c_JOY_UP])         d = DIR_U;
    else if (v[c_JOY_DOWN])  d = DIR_D;
    else if (v[c_JOY_LEFT])  d = DIR_L;
    else if (v[c_JOY_RIGHT]) d = DIR_R;
    else                     d = DIR_NONE;
    return d;
  endfunction

  function automatic logic [3:0] dir_to_bits(input dir_t d);
    logic [3:0] b;
    b = 4'b0000;
    case (d)
      DIR_U:   b[c_JOY_UP]    = 1'b1;
      DIR_D:   b[c_JOY_DOWN]  = 1'b1;
      DIR_L:   b[c_JOY_LEFT]  = 1'b1;
      DIR_R:   b[c_JOY_RIGHT] = 1'b1;
      default: b = 4'b0000;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_input_mapper_debounce.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Brief    : One-bit debouncer; q follows d after CYCLES consecutive differing samples.
// Revision : 1.0  initial release
// ============================================================================
module input_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int                  c_CNT_W    = $clog2(CYCLES + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(CYCLES - 1);

  logic               r_q;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_q   <= d;
      r_cnt <= '0;
    end else if (r_cnt != {c_CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_mapper
// Brief    : Debounced joystick/coin/start mapping to active-low arcade ports.
// Revision : 1.0  initial release
// ============================================================================
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int COIN_PULSE_CYCLES = 1000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         four_way,
  input  logic [NUM_PLAYERS*16-1:0]    joystick,
  output logic [(NUM_PLAYERS+1)*8-1:0] ports,
  output logic [NUM_PLAYERS-1:0]       coin_active
);

  localparam int                  c_PORT_W    = (NUM_PLAYERS + 1) * 8;
  localparam logic [c_PORT_W-1:0] c_PORT_IDLE = (ACTIVE_LOW != 0) ? {c_PORT_W{1'b1}} : {c_PORT_W{1'b0}};
  localparam int                  c_PCNT_W    = $clog2(COIN_PULSE_CYCLES + 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(COIN_PULSE_CYCLES - 1);

  logic [NUM_PLAYERS-1:0][c_RAW_BITS-1:0] w_deb;
  logic [NUM_PLAYERS-1:0][3:0]            w_dir_act;
  logic [NUM_PLAYERS-1:0]                 w_pulse_next;
  logic [NUM_PLAYERS-1:0]                 w_start_act;
  logic [c_PORT_W-1:0]                    w_ports_act;
  logic [c_PORT_W-1:0]                    r_ports;
  logic [NUM_PLAYERS-1:0]                 r_coin_active;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic w_unused_hi;
    assign w_unused_hi = ^joystick[p*16+c_RAW_BITS +: 16-c_RAW_BITS];

    for (genvar b = 0; b < c_RAW_BITS; b++) begin : g_bit
      input_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .d     (joystick[p*16+b]),
        .q     (w_deb[p][b])
      );
    end

    // ---- 4-way filter: last_dir follows new presses, falls back on release
    dir_t       r_last_dir, w_last_next;
    logic [3:0] r_prev_dir;
    logic [3:0] w_dirs, w_new;

    assign w_dirs = w_deb[p][3:0];
    assign w_new  = w_dirs & ~r_prev_dir;

    always_comb begin
      w_last_next = r_last_dir;
      if (!enable)
        w_last_next = DIR_NONE;
      else if (|w_new)
        w_last_next = dir_from_bits(w_new);
      else if ((w_dirs & dir_to_bits(r_last_dir)) == 4'b0000)
        w_last_next = dir_from_bits(w_dirs);
    end

    assign w_dir_act[p] = !enable  ? 4'b0000 :
                          four_way ? dir_to_bits(w_last_next) : w_dirs;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_last_dir <= DIR_NONE;
        r_prev_dir <= 4'b0000;
      end else begin
        r_last_dir <= w_last_next;
        r_prev_dir <= w_dirs;
      end
    end

    // ---- coin FSM
    coin_state_t         r_state, w_state_next;
    logic [c_PCNT_W-1:0] r_pcnt, w_pcnt_next;
    logic                r_coin_prev;
    logic                w_coin;

    assign w_coin = w_deb[p][c_JOY_COIN];

    always_comb begin
      w_state_next = r_state;
      w_pcnt_next  = r_pcnt;
      case (r_state)
        COIN_IDLE: begin
          if (w_coin && !r_coin_prev) begin
            w_state_next = COIN_PULSE;
            w_pcnt_next  = '0;
          end
        end
        COIN_PULSE: begin
          if (r_pcnt == c_PCNT_LAST) w_state_next = COIN_WAIT_RELEASE;
          else                       w_pcnt_next  = r_pcnt + 1'b1;
        end
        COIN_WAIT_RELEASE: begin
          if (!w_coin) w_state_next = COIN_IDLE;
        end
        default: w_state_next = COIN_IDLE;
      endcase
      if (!enable) w_state_next = COIN_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state     <= COIN_IDLE;
        r_pcnt      <= '0;
        r_coin_prev <= 1'b0;
      end else begin
        r_state     <= w_state_next;
        r_pcnt      <= w_pcnt_next;
        r_coin_prev <= w_coin;
      end
    end

    assign w_pulse_next[p] = (w_state_next == COIN_PULSE);
    assign w_start_act[p]  = enable & w_deb[p][c_JOY_START];
  end

  always_comb begin
    w_ports_act = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_ports_act[p]              = w_pulse_next[p];
      w_ports_act[4+p]            = w_start_act[p];
      w_ports_act[(p+1)*8 +: 4]   = w_dir_act[p];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ports       <= c_PORT_IDLE;
      r_coin_active <= '0;
    end else begin
      r_ports       <= (ACTIVE_LOW != 0) ? ~w_ports_act : w_ports_act;
      r_coin_active <= w_pulse_next;
    end
  end

  assign ports       = r_ports;
  assign coin_active = r_coin_active;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_arcade_input_mapper
// Brief    : Directed self-checking bench for arcade_input_mapper (2 players).
// Revision : 1.0  initial release
// ============================================================================
module tb_arcade_input_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        four_way = 1'b1;
  logic [31:0] joystick = '0;
  logic [23:0] ports;
  logic [1:0]  coin_active;

  int n_checks = 0;
  int n_pass   = 0;

  arcade_input_mapper #(
    .NUM_PLAYERS       (2),
    .DEBOUNCE_CYCLES   (4),
    .COIN_PULSE_CYCLES (8),
    .ACTIVE_LOW        (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .four_way    (four_way),
    .joystick    (joystick),
    .ports       (ports),
    .coin_active (coin_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts cycles over a window where coin pulse and port bit are active.
  task automatic count_coin(input int cycles, input int p, output int n_act, output int n_port);
    n_act = 0;
    n_port = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (coin_active[p]) n_act++;
      if (!ports[p])      n_port++;
    end
  endtask

  initial begin
    int a0, a1, b0, b1;

    #2 reset = 1'b1;
    tick(2);
    check("reset_ports", 32'(ports), 32'hFFFFFF);
    check("reset_coin", 32'(coin_active), 32'h0);
    reset = 1'b0;
    tick(2);
    check("idle_ports", 32'(ports), 32'hFFFFFF);

    // Debounce: short glitch rejected, 4-cycle hold accepted on the 5th edge
    joystick[0] = 1'b1;
    tick(3);
    joystick[0] = 1'b0;
    tick(6);
    check("glitch_p0", 32'(ports[15:8]), 32'hFF);
    joystick[0] = 1'b1;
    tick(4);
    check("deb_edge4", 32'(ports[8]), 32'h1);
    tick(1);
    check("deb_edge5", 32'(ports[15:8]), 32'hFE);
    joystick[0] = 1'b0;
    tick(5);
    check("deb_release", 32'(ports[15:8]), 32'hFF);

    // 4-way: up, then add right, then drop right
    joystick[3] = 1'b1;
    tick(5);
    check("4w_up", 32'(ports[11:8]), 32'h7);
    joystick[0] = 1'b1;
    a0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if ($countones(~ports[11:8]) > 1) a0++;
    end
    check("4w_right", 32'(ports[11:8]), 32'hE);
    joystick[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if ($countones(~ports[11:8]) > 1) a0++;
    end
    check("4w_back_up", 32'(ports[11:8]), 32'h7);
    check("4w_onehot", 32'(a0), 32'h0);

    // 8-way pass-through, then back to 4-way keeping the newest direction
    joystick[0] = 1'b1;
    tick(5);
    four_way = 1'b0;
    tick(1);
    check("8w_diag", 32'(ports[11:8]), 32'h6);
    four_way = 1'b1;
    tick(1);
    check("4w_reentry", 32'(ports[11:8]), 32'hE);
    joystick = '0;
    tick(5);
    check("dirs_released", 32'(ports), 32'hFFFFFF);

    // Coin player 1 held 40 cycles: one 8-cycle pulse only
    joystick[20] = 1'b1;
    count_coin(40, 1, a1, b1);
    check("coin1_active_len", 32'(a1), 32'd8);
    check("coin1_port_len", 32'(b1), 32'd8);
    check("coin1_p0_quiet", 32'(coin_active[0]), 32'h0);
    joystick[20] = 1'b0;
    tick(6);

    // Simultaneous coins, independent pulses
    joystick[4]  = 1'b1;
    joystick[20] = 1'b1;
    tick(5);
    check("coin_both_start", 32'(coin_active), 32'h3);
    check("coin_both_ports", 32'(ports[7:0]), 32'hFC);
    count_coin(15, 0, a0, b0);
    check("coin0_len", 32'(a0 + 1), 32'd8);
    check("coin0_port_len", 32'(b0 + 1), 32'd8);
    joystick = '0;
    tick(6);

    // Reset during pulse cycle 3
    joystick[20] = 1'b1;
    tick(5);
    tick(2);
    check("pulse_running", 32'(coin_active), 32'h2);
    reset = 1'b1;
    joystick = '0;
    #1;
    check("rst_mid_ports", 32'(ports), 32'hFFFFFF);
    check("rst_mid_coin", 32'(coin_active), 32'h0);
    tick(2);
    reset = 1'b0;
    count_coin(20, 1, a1, b1);
    check("no_resume", 32'(a1 + b1), 32'h0);

    // enable gating with everything held
    joystick = {16'h0038, 16'h0038};
    tick(6);
    enable = 1'b0;
    tick(1);
    check("dis_ports", 32'(ports), 32'hFFFFFF);
    check("dis_coin", 32'(coin_active), 32'h0);
    tick(3);
    check("dis_hold", 32'(ports), 32'hFFFFFF);
    enable = 1'b1;
    tick(1);
    check("en_ports", 32'(ports), 32'hF7F7CF);
    count_coin(12, 0, a0, b0);
    check("en_no_coin", 32'(a0 + b0 + 32'(coin_active[1])), 32'h0);
    joystick = {16'h0028, 16'h0028};
    tick(6);
    joystick = {16'h0038, 16'h0038};
    tick(5);
    check("repress_coin", 32'(coin_active), 32'h3);
    check("repress_sys", 32'(ports[7:0]), 32'hCC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of joysticks mapped (legal range 1..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable samples before a raw bit is accepted (legal range 1..65535).
REQ-003 Parameter COIN_PULSE_CYCLES, default 1000, length of the coin pulse in clk cycles (legal minimum 1).
REQ-004 Parameter ACTIVE_LOW, default 1, output polarity (1 = pressed reads 0, matching the all-ones idle input ports).
REQ-005 Port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: when low, all controls are forced inactive (used during ROM download).
REQ-008 Port four_way, input, 1 bit: 1 selects 4-way joystick filtering, 0 selects 8-way pass-through.
REQ-009 Port joystick, input, NUM_PLAYERS*16 bits: one 16-bit word per player; bit 0 right, 1 left, 2 down, 3 up, 4 coin, 5 start; all other bits ignored.
REQ-010 Port ports, output, (NUM_PLAYERS+1)*8 bits: byte 0 is the system port, byte p+1 is the player-p port.
REQ-011 Port coin_active, output, NUM_PLAYERS bits: high while each player's coin pulse is running; always active-high.

Function
REQ-012 Each used raw bit (right, left, down, up, coin, start) of each player SHALL pass through its own debouncer.
REQ-013 Debouncer SHALL change state only after its input has differed from the current state for DEBOUNCE_CYCLES consecutive rising edges.
- Any sample that matches the current state SHALL clear the debouncer counter.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL saturate and never wrap.
REQ-015 System port SHALL carry coin pulse p on bit p and debounced start p on bit 4+p.
- Bits for unused players SHALL sit at the inactive level.
REQ-016 Player port bits [3:0] SHALL be the filtered up/down/left/right directions; bits [7:4] SHALL sit at the inactive level.
REQ-017 All outputs SHALL be registered; a debounced change SHALL appear on ports exactly one edge after the debouncer state changes.
REQ-018 When four_way=0, directions SHALL pass through unchanged, diagonals included.
REQ-019 When four_way=1, each player SHALL hold a registered last_dir in {NONE,U,D,L,R}, and at most one direction bit SHALL be active.
REQ-020 4-way rule, newly pressed direction: a direction newly asserted this cycle SHALL become last_dir; if several are new in the same cycle, priority is U>D>L>R.
REQ-021 4-way rule, release: if last_dir is released while other directions remain held, the highest-priority held direction SHALL be taken; if none are held, last_dir SHALL become NONE.
REQ-022 Toggling four_way SHALL take effect on the next edge; last_dir SHALL be recomputed without glitching more than one bit active.
REQ-023 Coin FSM per player, states IDLE -> PULSE -> WAIT_RELEASE -> IDLE:
- IDLE -> PULSE on a debounced coin rising edge.
- PULSE lasts exactly COIN_PULSE_CYCLES cycles, then goes to WAIT_RELEASE.
- WAIT_RELEASE -> IDLE once the debounced coin is low.
REQ-024 Coin presses arriving during PULSE or WAIT_RELEASE SHALL be ignored; no pulses are queued.
REQ-025 Simultaneous coins from several players SHALL each produce an independent pulse.
REQ-026 enable=0 SHALL force all outputs inactive on the next edge, abort coin FSMs to IDLE, and set last_dir to NONE; debouncers SHALL keep running.

Reset
REQ-027 Reset assertion SHALL immediately set all debouncers released with counters at 0, coin FSMs to IDLE, last_dir to NONE, coin_active to 0, and ports to the inactive level (all ones when ACTIVE_LOW=1).
REQ-028 Reset mid-pulse SHALL terminate the pulse with no residual output after release.
REQ-029 After reset release, an input already held SHALL still need DEBOUNCE_CYCLES stable edges before it is recognised.

Structure
REQ-030 Package arcade_input_pkg SHALL hold the joystick bit-index constants, the dir_t enum {NONE,U,D,L,R}, and the coin_state_t enum.
REQ-031 Sub-module input_debounce (one bit, parameter CYCLES, ports clk, reset, d, q) SHALL be instantiated per raw bit.
- The 4-way logic and coin FSM stay in arcade_input_mapper.

Verification (NUM_PLAYERS=2, DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=8, ACTIVE_LOW=1)
REQ-032 Debounce: player-0 right pulsed high for 3 cycles then low -> ports[15:8] stays 8'hFF; held 4 cycles -> ports[8]=0 on the 5th edge.
REQ-033 4-way: hold up, then add right -> ports[11:8]=4'b1110 (right only); release right -> 4'b0111 (up only); never two bits 0.
REQ-034 Coin: player-1 coin held 40 cycles -> coin_active[1]=1 for exactly 8 cycles and ports[1]=0 for exactly 8 cycles; second press during hold -> no pulse.
REQ-035 Reset at pulse cycle 3 -> ports=24'hFFFFFF and coin_active=0 immediately; no pulse resumes.
REQ-036 enable=0 with all inputs held -> ports=24'hFFFFFF next edge; enable=1 -> directions return within 1 edge, coin requires release and re-press.
